// File: rtl/pmem_arb_pkg.sv
// Shared types and default widths for the physical-memory arbiter.
package pmem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        I    = 2'd1,
        D    = 2'd2
    } arb_client_e;

endpackage

// File: rtl/pmem_arb_pick.sv
// Combinational winner select between I and D requests.
// PMEM_ARB_RR_EN selects round-robin on a tie; otherwise D always wins a tie.
module pmem_arb_pick
    import pmem_arb_pkg::*;
(
    input  logic        i_req,
    input  logic        d_req,
`ifdef PMEM_ARB_RR_EN
    input  arb_client_e last_grant,
`endif
    output arb_client_e winner
);

    always_comb begin
        winner = NONE;
        if (i_req && d_req) begin
`ifdef PMEM_ARB_RR_EN
            winner = (last_grant == D) ? I : D;
`else
            winner = D;
`endif
        end else if (d_req) begin
            winner = D;
        end else if (i_req) begin
            winner = I;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates whole-line I-cache / D-cache transfers onto one physical-memory port.
// Optional round-robin tie-break when PMEM_ARB_RR_EN is defined.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_e        state_q, state_d;
    arb_client_e       mask_q, mask_d;
    arb_client_e       winner;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
    logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
    logic              i_req, d_req;

    // mask keeps a cache that still asserts its request after resp from re-winning
    assign i_req = (state_q == IDLE) && i_pmem_read && (mask_q != I);
    assign d_req = (state_q == IDLE) && (d_pmem_read || d_pmem_write) && (mask_q != D);

`ifdef PMEM_ARB_RR_EN
    arb_client_e last_grant_q, last_grant_d;

    pmem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant_q),
        .winner     (winner)
    );
`else
    pmem_arb_pick u_pick (
        .i_req  (i_req),
        .d_req  (d_req),
        .winner (winner)
    );
`endif

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
`ifdef PMEM_ARB_RR_EN
        last_grant_d   = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                mask_d = NONE;
                if (winner == D) begin
                    state_d        = D_BUSY;
                    pmem_address_d = d_pmem_address;
                    pmem_wdata_d   = d_pmem_wdata;
                    pmem_write_d   = d_pmem_write;
                    pmem_read_d    = d_pmem_read && !d_pmem_write;
`ifdef PMEM_ARB_RR_EN
                    last_grant_d   = D;
`endif
                end else if (winner == I) begin
                    state_d        = I_BUSY;
                    pmem_address_d = i_pmem_address;
                    pmem_read_d    = 1'b1;
                    pmem_write_d   = 1'b0;
`ifdef PMEM_ARB_RR_EN
                    last_grant_d   = I;
`endif
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    mask_d       = (state_q == I_BUSY) ? I : D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mask_q         <= NONE;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
`ifdef PMEM_ARB_RR_EN
            last_grant_q   <= D;
`endif
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
`ifdef PMEM_ARB_RR_EN
            last_grant_q   <= last_grant_d;
`endif
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign i_pmem_resp  = pmem_resp && (state_q == I_BUSY);
    assign d_pmem_resp  = pmem_resp && (state_q == D_BUSY);

    // Simultaneous D read and write is illegal; the write is taken if it happens
    d_rw_conflict: assert property (@(posedge clk) disable iff (!rst_n)
        !(winner == D && d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model (honours PMEM_ARB_RR_EN).
module tb_pmem_arbiter;
    import pmem_arb_pkg::*;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int N_TXN = 1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [LW-1:0] wd;
        wd = {8{32'hDEAD_BEEF}};
        rst_n = 1'b0;
        idle_inputs();
        pmem_resp = 1'b1;
        #3;
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read got=%b exp=0", pmem_read); end
        checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write got=%b exp=0", pmem_write); end
        checks++; if (pmem_address !== '0) begin errors++; $display("FAIL reset_pmem_address got=%h exp=0", pmem_address); end
        checks++; if (pmem_wdata !== '0) begin errors++; $display("FAIL reset_pmem_wdata got=%h exp=0", pmem_wdata); end
        checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin errors++; $display("FAIL reset_resp got=%b exp=00", {i_pmem_resp, d_pmem_resp}); end
        @(negedge clk);
        rst_n = 1'b1;
        pmem_resp = 1'b0;
        cyc();
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0040; d_pmem_wdata = wd;
        cyc();
        checks++; if (pmem_write !== 1'b1 || pmem_address !== 32'h40) begin errors++; $display("FAIL reset_dwrite_grant got=%b/%h exp=1/00000040", pmem_write, pmem_address); end
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        pmem_resp = 1'b1;
        #1;
        checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_async_drop got=%b exp=0", pmem_write); end
        checks++; if (d_pmem_resp !== 1'b0) begin errors++; $display("FAIL reset_no_dresp got=%b exp=0", d_pmem_resp); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        cyc();
        checks++; if ({pmem_read, pmem_write} !== 2'b00 || pmem_address !== '0) begin errors++; $display("FAIL reset_release_idle got=%b%b/%h exp=00/0", pmem_read, pmem_write, pmem_address); end
        $display("test_reset done");
    endtask

    task automatic test_i_read();
        logic [LW-1:0] a5;
        a5 = {32{8'hA5}};
        do_reset();
        cyc();
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0060;
        #1;
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL iread_early got=%b exp=0", pmem_read); end
        cyc();
        checks++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h60) begin errors++; $display("FAIL iread_grant got=%b%b/%h exp=10/00000060", pmem_read, pmem_write, pmem_address); end
        repeat (4) begin
            checks++; if (i_pmem_resp !== 1'b0 || pmem_read !== 1'b1) begin errors++; $display("FAIL iread_wait got resp=%b rd=%b exp resp=0 rd=1", i_pmem_resp, pmem_read); end
            cyc();
        end
        pmem_resp = 1'b1; pmem_rdata = a5;
        #1;
        checks++; if (i_pmem_resp !== 1'b1 || i_pmem_rdata !== a5) begin errors++; $display("FAIL iread_resp got=%b/%h exp=1/%h", i_pmem_resp, i_pmem_rdata, a5); end
        checks++; if (d_pmem_resp !== 1'b0) begin errors++; $display("FAIL iread_no_dresp got=%b exp=0", d_pmem_resp); end
        cyc();
        pmem_resp = 1'b0; i_pmem_read = 1'b0;
        #1;
        checks++; if (i_pmem_resp !== 1'b0 || pmem_read !== 1'b0) begin errors++; $display("FAIL iread_one_cycle got resp=%b rd=%b exp 0/0", i_pmem_resp, pmem_read); end
        $display("test_i_read done");
    endtask

    task automatic test_priority();
        arb_client_e   first;
        logic [LW-1:0] wd;
        wd = {8{32'h1234_5678}};
`ifdef PMEM_ARB_RR_EN
        first = I;
`else
        first = D;
`endif
        do_reset();
        cyc();
        i_pmem_read = 1'b1; i_pmem_address = 32'h100;
        d_pmem_write = 1'b1; d_pmem_address = 32'h200; d_pmem_wdata = wd;
        for (int t = 0; t < 2; t++) begin
            arb_client_e cur;
            cur = (t == 0) ? first : ((first == D) ? I : D);
            cyc();
            if (cur == D) begin
                checks++; if ({pmem_read, pmem_write} !== 2'b01 || pmem_address !== 32'h200 || pmem_wdata !== wd) begin errors++; $display("FAIL prio_d_grant[%0d] got=%b%b/%h exp=01/00000200", t, pmem_read, pmem_write, pmem_address); end
            end else begin
                checks++; if ({pmem_read, pmem_write} !== 2'b10 || pmem_address !== 32'h100) begin errors++; $display("FAIL prio_i_grant[%0d] got=%b%b/%h exp=10/00000100", t, pmem_read, pmem_write, pmem_address); end
            end
            cyc();
            pmem_resp = 1'b1;
            #1;
            checks++; if ({i_pmem_resp, d_pmem_resp} !== ((cur == I) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL prio_resp[%0d] got=%b%b exp_owner=%s", t, i_pmem_resp, d_pmem_resp, cur.name()); end
            cyc();
            pmem_resp = 1'b0;
            if (cur == D) d_pmem_write = 1'b0; else i_pmem_read = 1'b0;
            #1;
            checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL prio_gap[%0d] got=%b%b exp=00", t, pmem_read, pmem_write); end
        end
        $display("test_priority done first=%s", first.name());
    endtask

    task automatic test_mask();
        do_reset();
        cyc();
        d_pmem_read = 1'b1; d_pmem_address = 32'h80;
        cyc();
        checks++; if (pmem_read !== 1'b1 || pmem_address !== 32'h80) begin errors++; $display("FAIL mask_grant got=%b/%h exp=1/00000080", pmem_read, pmem_address); end
        pmem_resp = 1'b1;
        #1;
        checks++; if (d_pmem_resp !== 1'b1) begin errors++; $display("FAIL mask_resp got=%b exp=1", d_pmem_resp); end
        cyc();
        pmem_resp = 1'b0;
        #1;
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL mask_idle got=%b exp=0", pmem_read); end
        cyc();
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL mask_blocked got=%b exp=0", pmem_read); end
        cyc();
        checks++; if (pmem_read !== 1'b1 || pmem_address !== 32'h80) begin errors++; $display("FAIL mask_regrant got=%b/%h exp=1/00000080", pmem_read, pmem_address); end
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0; d_pmem_read = 1'b0;
        $display("test_mask done");
    endtask

    task automatic test_random();
        bit            act[2], stl[2], wr[2], drv[2];
        int            gap[2];
        logic [AW-1:0] adr[2];
        logic [LW-1:0] wd[2];
        int            issued, done, mem_wait, cycle;
        arb_client_e   m_owner, m_mask, m_last, win;
        logic          m_wr, exp_rd, exp_wr, exp_ir, exp_dr, i_el, d_el;
        logic [AW-1:0] m_addr;
        logic [LW-1:0] m_wdata;
        issued = 0; done = 0; mem_wait = -1; cycle = 0;
        m_owner = NONE; m_mask = NONE; m_last = D; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
        for (int c = 0; c < 2; c++) begin
            act[c] = 0; stl[c] = 0; wr[c] = 0; drv[c] = 0; gap[c] = 0; adr[c] = '0; wd[c] = '0;
        end
        do_reset();
        while (done < N_TXN && cycle < 60000) begin
            cyc();
            cycle++;
            exp_rd = (m_owner == I) || (m_owner == D && !m_wr);
            exp_wr = (m_owner == D) && m_wr;
            checks++; if (pmem_read !== exp_rd || pmem_write !== exp_wr) begin errors++; $display("FAIL rnd_strobe cyc=%0d got=%b%b exp=%b%b", cycle, pmem_read, pmem_write, exp_rd, exp_wr); end
            checks++; if (pmem_read === 1'b1 && pmem_write === 1'b1) begin errors++; $display("FAIL rnd_both_strobes cyc=%0d got=11 exp=not both", cycle); end
            if (m_owner != NONE) begin
                checks++; if (pmem_address !== m_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cycle, pmem_address, m_addr); end
                if (exp_wr) begin
                    checks++; if (pmem_wdata !== m_wdata) begin errors++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cycle, pmem_wdata, m_wdata); end
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (act[c]) drv[c] = 1;
                else if (stl[c]) begin drv[c] = 1; stl[c] = 0; end
                else if (gap[c] > 0) begin drv[c] = 0; gap[c]--; end
                else if (issued < N_TXN && $urandom_range(0, 3) == 0) begin
                    act[c] = 1; drv[c] = 1; issued++;
                    adr[c] = $urandom() & 32'hFFFF_FFE0;
                    wr[c]  = (c == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
                    for (int k = 0; k < 8; k++) wd[c][k*32 +: 32] = $urandom();
                end else drv[c] = 0;
            end
            i_pmem_read    = drv[0];
            i_pmem_address = adr[0];
            d_pmem_read    = drv[1] && !wr[1];
            d_pmem_write   = drv[1] && wr[1];
            d_pmem_address = adr[1];
            d_pmem_wdata   = wd[1];
            if (pmem_read || pmem_write) begin
                if (mem_wait < 0) mem_wait = $urandom_range(0, 4);
                if (mem_wait == 0) begin pmem_resp = 1'b1; mem_wait = -1; end
                else begin pmem_resp = 1'b0; mem_wait--; end
            end else pmem_resp = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < 8; k++) pmem_rdata[k*32 +: 32] = $urandom();
            #1;
            exp_ir = (m_owner == I) && pmem_resp;
            exp_dr = (m_owner == D) && pmem_resp;
            checks++; if (i_pmem_resp !== exp_ir || d_pmem_resp !== exp_dr) begin errors++; $display("FAIL rnd_resp cyc=%0d got=%b%b exp=%b%b", cycle, i_pmem_resp, d_pmem_resp, exp_ir, exp_dr); end
            if (exp_ir || exp_dr) begin
                checks++; if ((exp_ir ? i_pmem_rdata : d_pmem_rdata) !== pmem_rdata) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cycle, exp_ir ? i_pmem_rdata : d_pmem_rdata, pmem_rdata); end
            end
            for (int c = 0; c < 2; c++) begin
                if ((c == 0) ? i_pmem_resp : d_pmem_resp) begin
                    if (!act[c]) begin errors++; $display("FAIL rnd_extra_resp cyc=%0d client=%0d got=resp exp=no outstanding request", cycle, c); end
                    act[c] = 0; done++;
                    stl[c] = ($urandom_range(0, 1) == 1);
                    gap[c] = $urandom_range(0, 2);
                end
            end
            if (m_owner != NONE) begin
                if (pmem_resp) begin m_mask = m_owner; m_owner = NONE; end
            end else begin
                i_el = drv[0] && (m_mask != I);
                d_el = drv[1] && (m_mask != D);
                m_mask = NONE;
                win = NONE;
                if (i_el && d_el) begin
`ifdef PMEM_ARB_RR_EN
                    win = (m_last == D) ? I : D;
`else
                    win = D;
`endif
                end else if (d_el) win = D;
                else if (i_el) win = I;
                if (win != NONE) begin
                    m_owner = win; m_last = win;
                    m_addr  = (win == D) ? adr[1] : adr[0];
                    m_wr    = (win == D) && wr[1];
                    m_wdata = wd[1];
                end
            end
        end
        checks++; if (done != N_TXN || issued != N_TXN) begin errors++; $display("FAIL rnd_completion got done=%0d issued=%0d exp=%0d in %0d cycles", done, issued, N_TXN, cycle); end
        idle_inputs();
        $display("test_random done txns=%0d cycles=%0d", done, cycle);
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_priority();
        test_mask();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Sits between the split L1 caches (I-cache, D-cache) and the single physical-memory port of the mp3 top level. It is directly upstream of physical_memory.
- Arbitrates full 256-bit line transfers. Only one client owns the memory port at a time.
- Address and write data are registered at grant, so pmem_* outputs are glitch-free and held stable for the whole transaction.

Parameters:
- ADDR_W, 32, byte address width of client and memory ports.
- LINE_W, 256, cache-line width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_pmem_read  in  1  I-cache line-fill request.
- i_pmem_address  in  ADDR_W  I-cache line address (bits [4:0] zero).
- i_pmem_rdata  out  LINE_W  fill data to I-cache.
- i_pmem_resp  out  1  I-cache transaction done.
- d_pmem_read  in  1  D-cache line-fill request.
- d_pmem_write  in  1  D-cache write-back request.
- d_pmem_address  in  ADDR_W  D-cache line address.
- d_pmem_wdata  in  LINE_W  D-cache write-back data.
- d_pmem_rdata  out  LINE_W  fill data to D-cache.
- d_pmem_resp  out  1  D-cache transaction done.
- pmem_read  out  1  memory read strobe (registered).
- pmem_write  out  1  memory write strobe (registered).
- pmem_address  out  ADDR_W  memory address (registered).
- pmem_wdata  out  LINE_W  memory write data (registered).
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory transaction done.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, mask=NONE.
  - i_pmem_resp=d_pmem_resp=0.
  - Reset mid-transaction abandons it with no resp to either client. Memory sees strobes drop asynchronously.
- States:
  - IDLE: no grant. pmem strobes are 0.
  - I_BUSY: I-cache owns the port. pmem_read=1.
  - D_BUSY: D-cache owns the port. pmem_read=d_read or pmem_write=d_write, as latched.
- Eligibility in IDLE:
  - i_req = i_pmem_read & (mask!=I).
  - d_req = (d_pmem_read|d_pmem_write) & (mask!=D).
- Priority: if both are eligible, D wins (fixed priority), except as noted under Optional Feature.
- Grant edge (IDLE to BUSY):
  - Latch the winner's address into pmem_address.
  - For D, latch wdata into pmem_wdata.
  - Set the strobe; it is first visible the cycle after the request. Request to pmem strobe latency is 1 cycle.
  - If D asserts read and write together: write wins and read is ignored. This is a protocol violation; flag it with an assertion.
- While BUSY:
  - Strobes, address and wdata are held constant. Client input changes are ignored.
  - Client resp = pmem_resp & (state matches client), combinational, same cycle as pmem_resp.
  - Both rdata outputs are continuously driven from pmem_rdata. Data is meaningful only with that client's resp.
  - On the pmem_resp edge: state goes to IDLE, strobes go to 0, and mask is set to the finishing client.
- mask:
  - Blocks the just-served client for exactly one IDLE cycle, covering a cache that still drives its request in the cycle after resp.
  - Cleared on any IDLE cycle.
  - Minimum spacing for back-to-back same-client transactions: resp cycle, 1 masked IDLE cycle, grant in the next IDLE cycle.
  - The other client may be granted in the first IDLE cycle after resp.
- Other guarantees:
  - No resp is ever sent to a non-owner.
  - pmem_read and pmem_write are never high together.
  - pmem_resp arriving in IDLE is ignored.

Optional Feature:
- Macro: PMEM_ARB_RR_EN.
- Defined: round-robin. A last_grant register (reset = D) gives priority on simultaneous eligibility to the client not granted last.
- Undefined: fixed D-over-I priority, and no last_grant register.

Decomposition:
- Package pmem_arb_pkg holds:
  - arb_state_e {IDLE, I_BUSY, D_BUSY}.
  - arb_client_e {NONE, I, D}.
  - localparams for ADDR_W and LINE_W defaults.
- Optional sub-module pmem_arb_pick: combinational winner select from i_req, d_req and last_grant, isolating the compile-time policy.

Test Plan:
1. Reset mid-D-write (rst_n low two cycles after grant, address 0x0000_0040) -> pmem_write drops immediately, no d_pmem_resp, state IDLE after release.
2. I-only read of 0x0000_0060, memory resp after 5 cycles with rdata=256'hA5.. -> pmem_read rises 1 cycle after request; i_pmem_resp is 1 for exactly one cycle with i_pmem_rdata=256'hA5..; d_pmem_resp stays 0.
3. I read 0x100 and D write 0x200 in the same cycle, fixed priority -> D is served first (pmem_write, address 0x200); I is granted the cycle after D's resp, with pmem_address=0x100.
4. Same as 3 with PMEM_ARB_RR_EN and last_grant=D -> I is served first, then D.
5. D holds d_pmem_read for one cycle past resp (0x0000_0080) -> no second transaction in the masked cycle; a re-asserted request is granted one cycle later.
6. Random I/D traffic, 1000 transactions -> strobes never high together; pmem_address/pmem_wdata stable throughout each transaction; each request gets exactly one resp.
